// File: rtl/ram_dp_param.sv
// Simple-dual-port synchronous RAM with selectable read-during-write policy,
// optional output register and a hardware clear engine that zeroes the array.
module ram_dp_param #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 2**ADDR_W,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clear,
  output logic              busy
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH-1);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              idle, wr_ok, rd_ok, rd_in;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata, rd_word;
  logic              pipe_vld;
  logic [DATA_W-1:0] pipe_data;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear walks the array once; a clear request while already clearing is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_C) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_IDLE: begin
        if (clear) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign idle  = (state_q == S_IDLE);
  assign wr_ok = idle & wr_en & ({1'b0, wr_addr} < DEPTH_C);
  assign rd_ok = idle & rd_en;
  assign rd_in = ({1'b0, rd_addr} < DEPTH_C);

  assign mem_we    = ~idle | wr_ok;
  assign mem_waddr = idle ? wr_addr : cnt_q;
  assign mem_wdata = idle ? wr_data : '0;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Out-of-range reads return zero; write-first bypasses the array on a hit.
  always_comb begin
    rd_word = '0;
    if (rd_in) begin
      rd_word = mem[rd_addr];
      if ((RDW_MODE != 0) && wr_ok && (wr_addr == rd_addr)) rd_word = wr_data;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              s1_vld_q;
      logic [DATA_W-1:0] s1_data_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_vld_q  <= 1'b0;
          s1_data_q <= '0;
        end else begin
          s1_vld_q <= rd_ok;
          if (rd_ok) s1_data_q <= rd_word;
        end
      end
      assign pipe_vld  = s1_vld_q;
      assign pipe_data = s1_data_q;
    end else begin : g_noreg
      assign pipe_vld  = rd_ok;
      assign pipe_data = rd_word;
    end
  endgenerate

  // rd_data only moves when a read completes, so it holds between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= pipe_vld;
      if (pipe_vld) rd_data_q <= pipe_data;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == S_CLEAR);

endmodule
